// File: rtl/gp_register_file.sv
// gp_register_file: parametrised register file with one write port, two tri-state read ports,
// an in-place increment/decrement unit with wrap pulse, and a flattened content view.
module gp_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                           clock,
    input  logic                           notReset,
    input  logic                           notLoad,
    input  logic [SEL_WIDTH-1:0]           loadSel,
    input  logic [DATA_WIDTH-1:0]          in,
    input  logic                           notOEA,
    input  logic [SEL_WIDTH-1:0]           selA,
    output logic [DATA_WIDTH-1:0]          outA,
    input  logic                           notOEB,
    input  logic [SEL_WIDTH-1:0]           selB,
    output logic [DATA_WIDTH-1:0]          outB,
    input  logic                           notInc,
    input  logic                           notDec,
    input  logic [SEL_WIDTH-1:0]           incSel,
    output logic                           wrap,
    output logic [NUM_REGS*DATA_WIDTH-1:0] content
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] cur, nxt, rd_a, rd_b;
    logic load_ok, count_ok, wrap_n;
    always_comb begin
        load_ok  = !notLoad && 32'(loadSel) < NUM_REGS;
        count_ok = (notInc ^ notDec) && 32'(incSel) < NUM_REGS && !(load_ok && loadSel == incSel);
        cur      = 32'(incSel) < NUM_REGS ? regs[incSel] : '0;
        nxt      = !notInc ? cur + 1'b1 : cur - 1'b1;
        wrap_n   = count_ok && (!notInc ? &cur : ~|cur);
        rd_a     = 32'(selA) < NUM_REGS ? regs[selA] : '0;
        rd_b     = 32'(selB) < NUM_REGS ? regs[selB] : '0;
    end
    assign outA = notOEA ? 'z : rd_a;
    assign outB = notOEB ? 'z : rd_b;
    // load has priority: count_ok already excludes a count colliding with the load target
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clock or negedge notReset) begin
            if (!notReset)
                regs[i] <= '0;
            else if (load_ok && 32'(loadSel) == i)
                regs[i] <= in;
            else if (count_ok && 32'(incSel) == i)
                regs[i] <= nxt;
        end
        assign content[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset)
            wrap <= 1'b0;
        else
            wrap <= wrap_n;
    end
endmodule

// File: tb/tb_gp_register_file.sv
// tb_gp_register_file: directed checks of gp_register_file at NUM_REGS=8 and NUM_REGS=6.
module tb_gp_register_file;
    logic        clock = 1'b0;
    logic        notReset = 1'b0;
    logic        notLoad = 1'b1, notOEA = 1'b1, notOEB = 1'b1, notInc = 1'b1, notDec = 1'b1;
    logic [2:0]  loadSel = '0, selA = '0, selB = '0, incSel = '0;
    logic [15:0] in = '0;
    tri1  [15:0] outA, outB;
    logic        wrap;
    logic [127:0] content;
    logic        v_notLoad = 1'b1, v_notOEA = 1'b1, v_notInc = 1'b1;
    logic [2:0]  v_loadSel = '0, v_selA = '0, v_incSel = '0;
    logic [15:0] v_in = '0;
    tri1  [15:0] v_outA, v_outB;
    logic        v_wrap;
    logic [95:0] v_content;
    int n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    gp_register_file u_dut (
        .clock(clock), .notReset(notReset), .notLoad(notLoad), .loadSel(loadSel), .in(in),
        .notOEA(notOEA), .selA(selA), .outA(outA), .notOEB(notOEB), .selB(selB), .outB(outB),
        .notInc(notInc), .notDec(notDec), .incSel(incSel), .wrap(wrap), .content(content)
    );

    gp_register_file #(.NUM_REGS(6)) u_dut6 (
        .clock(clock), .notReset(notReset), .notLoad(v_notLoad), .loadSel(v_loadSel), .in(v_in),
        .notOEA(v_notOEA), .selA(v_selA), .outA(v_outA), .notOEB(1'b1), .selB(3'd0), .outB(v_outB),
        .notInc(v_notInc), .notDec(1'b1), .incSel(v_incSel), .wrap(v_wrap), .content(v_content)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [2:0] sel, input logic [15:0] val);
        notLoad = 1'b0; loadSel = sel; in = val;
        cyc;
        notLoad = 1'b1;
    endtask

    function automatic logic [15:0] r(input int i);
        return content[i*16 +: 16];
    endfunction

    initial begin
        cyc; cyc;
        check("reset_content", content, '0);
        check("reset_wrap", wrap, 0);
        notReset = 1'b1;
        load(3, 16'h1234);
        check("r3_loaded", r(3), 16'h1234);
        selA = 3; notOEA = 1'b0;
        #2 notReset = 1'b0;
        #1;
        check("async_rst_content", content, '0);
        check("async_rst_outA", outA, 16'h0000);
        check("async_rst_wrap", wrap, 0);
        #1 notReset = 1'b1;
        cyc;
        load(2, 16'hBEEF);
        load(5, 16'h00FF);
        selA = 2; selB = 5; notOEA = 1'b0; notOEB = 1'b0;
        #1;
        check("read_A", outA, 16'hBEEF);
        check("read_B", outB, 16'h00FF);
        notOEB = 1'b1;
        #1;
        check("B_hiz_pulled", outB, 16'hFFFF);
        load(1, 16'hFFFE);
        notInc = 1'b0; incSel = 1;
        cyc;
        check("inc1_r1", r(1), 16'hFFFF);
        check("inc1_wrap", wrap, 0);
        cyc;
        check("inc2_r1", r(1), 16'h0000);
        check("inc2_wrap", wrap, 1);
        notInc = 1'b1;
        cyc;
        check("idle_wrap", wrap, 0);
        notDec = 1'b0;
        cyc;
        notDec = 1'b1;
        check("dec_r1", r(1), 16'hFFFF);
        check("dec_wrap", wrap, 1);
        load(4, 16'h0010);
        load(6, 16'h0007);
        notInc = 1'b0; incSel = 4;
        load(4, 16'h0100);
        check("coll_same_r4", r(4), 16'h0100);
        incSel = 6;
        load(4, 16'h0200);
        check("coll_diff_r4", r(4), 16'h0200);
        check("coll_diff_r6", r(6), 16'h0008);
        notDec = 1'b0;
        cyc;
        check("both_low_r6", r(6), 16'h0008);
        notInc = 1'b1; notDec = 1'b1;
        load(7, 16'hFFFF);
        notInc = 1'b0; incSel = 7;
        load(7, 16'h0005);
        notInc = 1'b1;
        check("coll_wrap_r7", r(7), 16'h0005);
        check("coll_wrap_flag", wrap, 0);
        load(0, 16'h0001);
        selA = 0; notOEA = 1'b0;
        notLoad = 1'b0; loadSel = 0; in = 16'hAAAA;
        #1;
        check("nobypass_pre", outA, 16'h0001);
        cyc;
        notLoad = 1'b1;
        check("nobypass_post", outA, 16'hAAAA);
        v_notLoad = 1'b0; v_loadSel = 2; v_in = 16'h5555;
        cyc;
        v_loadSel = 7; v_in = 16'h9999;
        cyc;
        v_notLoad = 1'b1;
        v_notInc = 1'b0; v_incSel = 7;
        cyc;
        v_notInc = 1'b1;
        check("n6_oor_load_inc", v_content, {48'h0, 16'h5555, 32'h0});
        check("n6_oor_wrap", v_wrap, 0);
        v_notOEA = 1'b0; v_selA = 7;
        #1;
        check("n6_oor_read", v_outA, 16'h0000);
        v_selA = 2;
        #1;
        check("n6_read_r2", v_outA, 16'h5555);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gp_register_file.md
# gp_register_file

Parametrised general-purpose register file for the CPU datapath: NUM_REGS registers of DATA_WIDTH bits, one write port from the data bus, two independent tri-state read ports onto buses A and B, and a per-cycle increment/decrement unit used for PC/SP-style pointer registers. It replaces discrete per-register instances and adds asynchronous reset, in-place counting and a wrap indication. A flattened content vector is exported so higher-level monitors can observe every register.

## Interface
- DATA_WIDTH, 16, bits per register
- NUM_REGS, 8, number of registers (2..2^SEL_WIDTH)
- SEL_WIDTH, 3, width of every register-select input

- clock  in  1  rising-edge clock
- notReset  in  1  asynchronous, active-low reset
- notLoad  in  1  active-low write enable
- loadSel  in  SEL_WIDTH  register written when notLoad=0
- in  in  DATA_WIDTH  write data
- notOEA  in  1  active-low output enable, port A
- selA  in  SEL_WIDTH  register driven on outA
- outA  out  DATA_WIDTH  tri-state read port A
- notOEB  in  1  active-low output enable, port B
- selB  in  SEL_WIDTH  register driven on outB
- outB  out  DATA_WIDTH  tri-state read port B
- notInc  in  1  active-low increment request
- notDec  in  1  active-low decrement request
- incSel  in  SEL_WIDTH  register targeted by inc/dec
- wrap  out  1  registered: last edge's inc/dec wrapped
- content  out  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Reset (notReset=0): all registers = 0, wrap = 0, immediately and independent of clock; held while low. Edges during reset are ignored.
- Write: on rising clock with notLoad=0 and loadSel < NUM_REGS, reg[loadSel] <= in. loadSel >= NUM_REGS: no register changes.
- Count: on rising clock, with exactly one of notInc/notDec low and incSel < NUM_REGS, reg[incSel] <= reg[incSel] ± 1 modulo 2^DATA_WIDTH. Both low: no count, wrap <= 0. incSel out of range: no count.
- Load and count on same register in same cycle: load wins; count discarded; wrap <= 0.
- Load and count on different registers: both take effect on the same edge.
- wrap <= 1 on an edge where an effective increment takes all-ones to 0, or an effective decrement takes 0 to all-ones; otherwise wrap <= 0 (one-cycle pulse).
- Read: outA = reg[selA] when notOEA=0, else high-Z (all bits). Same for B. Both ports may select the same register. Enabled read of out-of-range select drives 0.
- No write-through bypass: a read shows the pre-edge value until the edge, then the new value.
- content is always driven (never Z) and mirrors register state.

## Timing
- Write/count latency: 1 clock; value visible on outA/outB/content after the edge that performs it.
- Read path: purely combinational from selX/notOEX/register state; no clock latency.
- wrap valid the cycle after the causing edge; cleared by the next edge unless re-caused.
- Reset assertion mid-operation: registers, wrap and any enabled read port go to 0 without waiting for clock; deassertion takes effect at the first rising edge with notReset=1.
- All control inputs sampled only at rising clock (except read enables/selects and notReset).

## Test plan
- Reset: write 0x1234 to r3, pull notReset low between edges -> content and outA (selA=3, notOEA=0) read 0x0000 before the next edge; wrap=0.
- Write/read: load r2=0xBEEF, r5=0x00FF; selA=2, selB=5, both enabled -> outA=0xBEEF, outB=0x00FF; notOEB=1 -> outB all Z; out-of-range not applicable at NUM_REGS=8, so rerun with NUM_REGS=6, selA=7 -> outA=0x0000, load to sel 7 changes nothing.
- Count and wrap: r1=0xFFFE, notInc=0 for 2 edges -> r1=0xFFFF (wrap=0), then 0x0000 (wrap=1); next idle edge wrap=0; notDec=0 once -> r1=0xFFFF, wrap=1.
- Collisions: r4=0x0010, notLoad=0 loadSel=4 in=0x0100 with notInc=0 incSel=4 -> r4=0x0100; with incSel=6 (r6=0x0007) same edge -> r4=0x0100, r6=0x0008; notInc=notDec=0 -> no change.
- No bypass: r0=0x0001, selA=0 enabled, load in=0xAAAA -> outA=0x0001 until edge, 0xAAAA after.
